// File: rtl/inst_fetch_req_pkg.sv
// Shared core defines for the instruction fetch requester: defaults, hold-level
// encodings, FSM state type and the response-buffer entry layout.
package inst_fetch_req_pkg;

   localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   localparam logic [2:0] HOLD_NONE = 3'b000;
   localparam logic [2:0] HOLD_PC   = 3'b001;
   localparam logic [2:0] HOLD_PIPE = 3'b010;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_RESP
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] addr;
   } fetch_entry_t;

   function automatic logic [31:0] align_word(input logic [31:0] a);
      return a & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/inst_fetch_req_if.sv
// Instruction bus: single-outstanding request/grant with a separate read-data return.
interface inst_fetch_req_if;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/inst_fetch_req_resp_fifo.sv
// Two-entry response buffer of {inst, addr}; flush wins over push/pop.
module inst_resp_fifo
   import inst_fetch_req_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  fetch_entry_t din_i,
   output fetch_entry_t head_o,
   output logic [1:0]   count_o
);

   fetch_entry_t mem_q [2];
   logic         wr_q;
   logic         rd_q;
   logic [1:0]   count_q;
   logic         push_ok;
   logic         pop_ok;

   always_comb begin
      pop_ok  = pop_i && (count_q != 2'd0);
      push_ok = push_i && ((count_q != 2'd2) || pop_ok);
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int i = 0; i < 2; i++) mem_q[i] <= '0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         count_q <= 2'd0;
      end else if (flush_i) begin
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         count_q <= 2'd0;
      end else begin
         if (push_ok) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= ~wr_q;
         end
         if (pop_ok) rd_q <= ~rd_q;
         count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = count_q;

   // The issue throttle in the requester must keep this from ever firing.
   a_no_overflow : assert property (@(posedge clk) disable iff (rst_n)
      !(push_i && !flush_i && !pop_i && (count_q == 2'd2)));

endmodule

// File: rtl/inst_fetch_req.sv
// Instruction fetch requester: issues word fetches on the instruction bus,
// buffers responses and presents them to the fetch stage; handles jump/hold.
//
//  state  | meaning
//  -------+-------------------------------------------------
//  S_IDLE | no request on the bus, nothing outstanding
//  S_REQ  | ibus req asserted with a stable address, awaiting gnt
//  S_RESP | granted, awaiting rvalid (possibly for a killed fetch)
module inst_fetch_req
   import inst_fetch_req_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    jump_flag_i,
   input  logic [31:0]             jump_addr_i,
   input  logic [2:0]              hold_flag_i,
   inst_fetch_req_if.master        ibus,
   output logic [31:0]             inst_o,
   output logic [31:0]             inst_addr_o
);

   fetch_state_e state_q;
   logic [31:0]  pc_q;
   logic [31:0]  addr_q;
   logic [31:0]  resp_addr_q;
   logic         req_q;
   logic         kill_q;

   logic [31:0]  jump_pc_d;
   logic [31:0]  issue_addr_d;
   logic [1:0]   occ_d;
   logic         issue_ok_d;
   logic         push_d;
   logic         pop_d;
   logic [1:0]   fifo_cnt;
   fetch_entry_t fifo_head;
   fetch_entry_t fifo_din;

   always_comb begin
      jump_pc_d    = align_word(jump_addr_i);
      issue_addr_d = jump_flag_i ? jump_pc_d : pc_q;
      pop_d        = (fifo_cnt != 2'd0) && (hold_flag_i inside {HOLD_NONE, HOLD_PC}) && !jump_flag_i;
      push_d       = (state_q == S_RESP) && ibus.rvalid && !kill_q && !jump_flag_i;
      // A RESP transaction holds a slot whether still in flight or landing now.
      occ_d        = (jump_flag_i ? 2'd0 : (fifo_cnt - {1'b0, pop_d}))
                   + {1'b0, (state_q == S_RESP)};
      issue_ok_d   = (hold_flag_i == HOLD_NONE) && (occ_d < 2'd2);
      fifo_din     = '{inst: ibus.rdata, addr: resp_addr_q};
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         addr_q      <= RESET_PC;
         resp_addr_q <= '0;
         req_q       <= 1'b0;
         kill_q      <= 1'b0;
      end else begin
         if (jump_flag_i) pc_q <= jump_pc_d;
         unique case (state_q)
            S_IDLE: begin
               if (issue_ok_d) begin
                  state_q <= S_REQ;
                  req_q   <= 1'b1;
                  addr_q  <= issue_addr_d;
               end
            end
            S_REQ: begin
               if (ibus.gnt) begin
                  state_q     <= S_RESP;
                  req_q       <= 1'b0;
                  resp_addr_q <= addr_q;
                  kill_q      <= kill_q | jump_flag_i;
                  // A killed fetch must not advance a redirected pc.
                  if (!jump_flag_i && !kill_q) pc_q <= addr_q + 32'd4;
               end else if (jump_flag_i) begin
                  kill_q <= 1'b1;
               end
            end
            S_RESP: begin
               if (ibus.rvalid) begin
                  kill_q <= 1'b0;
                  if (issue_ok_d) begin
                     state_q <= S_REQ;
                     req_q   <= 1'b1;
                     addr_q  <= issue_addr_d;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else if (jump_flag_i) begin
                  kill_q <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   inst_resp_fifo u_resp_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (jump_flag_i),
      .push_i  (push_d),
      .pop_i   (pop_d),
      .din_i   (fifo_din),
      .head_o  (fifo_head),
      .count_o (fifo_cnt)
   );

   assign ibus.req    = req_q;
   assign ibus.addr   = addr_q;
   assign inst_o      = (fifo_cnt == 2'd0) ? NOP_INST : fifo_head.inst;
   assign inst_addr_o = (fifo_cnt == 2'd0) ? 32'h0 : fifo_head.addr;

endmodule

// File: tb/tb_inst_fetch_req.sv
// Directed bench for inst_fetch_req with a latency-configurable memory model.
module tb_inst_fetch_req;
   import inst_fetch_req_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        jump;
   logic [31:0] jaddr;
   logic [2:0]  hold;
   logic [31:0] inst;
   logic [31:0] inst_addr;

   logic        gnt_en;
   logic        stray;
   int          lat;
   logic        rv_q = 1'b0;
   logic        pend = 1'b0;
   int          dly = 0;
   logic [31:0] rd_q = '0;
   logic [31:0] paddr = '0;

   logic [31:0] iss_q[$];
   logic [31:0] cons_a[$];
   logic [31:0] cons_d[$];

   int vec = 0;
   int errs = 0;

   always #5 clk = ~clk;

   inst_fetch_req_if bus();

   inst_fetch_req dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .jump_flag_i (jump),
      .jump_addr_i (jaddr),
      .hold_flag_i (hold),
      .ibus        (bus),
      .inst_o      (inst),
      .inst_addr_o (inst_addr)
   );

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return {8'hAB, a[23:0]};
   endfunction

   assign bus.gnt    = bus.req & gnt_en;
   assign bus.rvalid = rv_q | stray;
   assign bus.rdata  = rd_q;

   always @(posedge clk) begin
      rv_q <= 1'b0;
      if (bus.req && bus.gnt) begin
         iss_q.push_back(bus.addr);
         if (lat == 0) begin
            rv_q <= 1'b1;
            rd_q <= mdata(bus.addr);
         end else begin
            pend  <= 1'b1;
            dly   <= lat - 1;
            paddr <= bus.addr;
         end
      end else if (pend) begin
         if (dly == 0) begin
            rv_q <= 1'b1;
            rd_q <= mdata(paddr);
            pend <= 1'b0;
         end else begin
            dly <= dly - 1;
         end
      end
   end

   // An entry is consumed on any cycle it is presented and the pipeline can pop.
   always @(negedge clk) begin
      if (rst_n === 1'b0 && inst !== NOP_INST_DEF && hold < HOLD_PIPE && !jump) begin
         cons_a.push_back(inst_addr);
         cons_d.push_back(inst);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      iss_q.delete();
      cons_a.delete();
      cons_d.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b1; jump = 1'b0; jaddr = '0; hold = HOLD_NONE;
      gnt_en = 1'b1; lat = 0; stray = 1'b0;
      tick(3);
      clear_logs();
      rst_n = 1'b0;
   endtask

   task automatic test_reset();
      tick(2);
      vec++; if (bus.req !== 1'b0) begin errs++; $display("FAIL reset_req: observed %b, required 0", bus.req); end
      vec++; if (bus.addr !== 32'h0) begin errs++; $display("FAIL reset_addr: observed %h, required 00000000", bus.addr); end
      vec++; if (inst !== 32'h13) begin errs++; $display("FAIL reset_inst: observed %h, required 00000013", inst); end
      vec++; if (inst_addr !== 32'h0) begin errs++; $display("FAIL reset_inst_addr: observed %h, required 00000000", inst_addr); end
   endtask

   task automatic test_stream();
      do_reset();
      tick(9);
      vec++; if (iss_q.size() != 4) begin errs++; $display("FAIL stream_issue_cnt: observed %0d, required 4", iss_q.size()); end
      vec++; if (iss_q[0] !== 32'h0 || iss_q[1] !== 32'h4 || iss_q[2] !== 32'h8) begin errs++; $display("FAIL stream_issue_addr: observed %h %h %h, required 0 4 8", iss_q[0], iss_q[1], iss_q[2]); end
      vec++; if (cons_a.size() != 3) begin errs++; $display("FAIL stream_cons_cnt: observed %0d, required 3", cons_a.size()); end
      for (int i = 0; i < 3; i++) begin
         vec++; if (cons_a[i] !== 32'(4 * i) || cons_d[i] !== mdata(32'(4 * i))) begin errs++; $display("FAIL stream_word%0d: observed %h/%h, required %h/%h", i, cons_a[i], cons_d[i], 32'(4 * i), mdata(32'(4 * i))); end
      end
   endtask

   task automatic test_hold_full();
      do_reset();
      tick(5);
      hold = HOLD_PIPE;
      clear_logs();
      tick(5);
      vec++; if (iss_q.size() != 1 || iss_q[0] !== 32'h8) begin errs++; $display("FAIL holdfull_issue: observed n=%0d first=%h, required n=1 first=00000008", iss_q.size(), iss_q[0]); end
      vec++; if (bus.req !== 1'b0) begin errs++; $display("FAIL holdfull_req: observed %b, required 0", bus.req); end
      vec++; if (inst_addr !== 32'h4 || inst !== mdata(32'h4)) begin errs++; $display("FAIL holdfull_head: observed %h/%h, required 00000004/%h", inst_addr, inst, mdata(32'h4)); end
      vec++; if (cons_a.size() != 0) begin errs++; $display("FAIL holdfull_nopop: observed %0d pops, required 0", cons_a.size()); end
      hold = HOLD_NONE;
      tick(10);
      for (int i = 0; i < 4; i++) begin
         vec++; if (cons_a[i] !== 32'(4 + 4 * i) || cons_d[i] !== mdata(32'(4 + 4 * i))) begin errs++; $display("FAIL holdfull_drain%0d: observed %h/%h, required %h", i, cons_a[i], cons_d[i], 32'(4 + 4 * i)); end
      end
   endtask

   task automatic test_hold_pc();
      do_reset();
      tick(5);
      hold = HOLD_PC;
      clear_logs();
      tick(5);
      vec++; if (iss_q.size() != 1 || iss_q[0] !== 32'h8) begin errs++; $display("FAIL holdpc_issue: observed n=%0d first=%h, required n=1 first=00000008", iss_q.size(), iss_q[0]); end
      vec++; if (cons_a.size() != 2 || cons_a[0] !== 32'h4 || cons_a[1] !== 32'h8) begin errs++; $display("FAIL holdpc_drain: observed n=%0d %h %h, required 2 4 8", cons_a.size(), cons_a[0], cons_a[1]); end
      vec++; if (inst !== 32'h13 || inst_addr !== 32'h0) begin errs++; $display("FAIL holdpc_nop: observed %h/%h, required 00000013/00000000", inst, inst_addr); end
      vec++; if (bus.req !== 1'b0) begin errs++; $display("FAIL holdpc_req: observed %b, required 0", bus.req); end
      hold = HOLD_NONE;
   endtask

   task automatic test_jump_resp();
      bit found = 0;
      do_reset();
      lat = 1;
      for (int i = 0; i < 60 && !found; i++) begin
         tick(1);
         if (iss_q.size() > 0 && iss_q[iss_q.size() - 1] == 32'h10) found = 1;
      end
      vec++; if (!found) begin errs++; $display("FAIL jresp_wait: observed timeout, required grant of 00000010"); end
      jump = 1'b1; jaddr = 32'h0000_0103;
      clear_logs();
      tick(1);
      jump = 1'b0;
      vec++; if (inst !== 32'h13) begin errs++; $display("FAIL jresp_nop: observed %h, required 00000013", inst); end
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick(1);
         if (cons_a.size() > 0) found = 1;
      end
      vec++; if (!found) begin errs++; $display("FAIL jresp_arrive: observed timeout, required data for 00000100"); end
      vec++; if (iss_q[0] !== 32'h100) begin errs++; $display("FAIL jresp_next_req: observed %h, required 00000100", iss_q[0]); end
      vec++; if (cons_a[0] !== 32'h100 || cons_d[0] !== mdata(32'h100)) begin errs++; $display("FAIL jresp_first_word: observed %h/%h, required 00000100/%h", cons_a[0], cons_d[0], mdata(32'h100)); end
   endtask

   task automatic test_jump_req();
      bit found = 0;
      do_reset();
      gnt_en = 1'b0;
      tick(1);
      vec++; if (bus.req !== 1'b1 || bus.addr !== 32'h0) begin errs++; $display("FAIL jreq_start: observed %b/%h, required 1/00000000", bus.req, bus.addr); end
      jump = 1'b1; jaddr = 32'h0000_0203;
      tick(1);
      jump = 1'b0;
      for (int i = 0; i < 2; i++) begin
         vec++; if (bus.req !== 1'b1 || bus.addr !== 32'h0) begin errs++; $display("FAIL jreq_stable%0d: observed %b/%h, required 1/00000000", i, bus.req, bus.addr); end
         tick(1);
      end
      gnt_en = 1'b1;
      for (int i = 0; i < 30 && !found; i++) begin
         tick(1);
         if (cons_a.size() > 0) found = 1;
      end
      vec++; if (!found) begin errs++; $display("FAIL jreq_arrive: observed timeout, required data for 00000200"); end
      vec++; if (iss_q.size() < 2 || iss_q[0] !== 32'h0 || iss_q[1] !== 32'h200) begin errs++; $display("FAIL jreq_issue: observed %h %h, required 0 200", iss_q[0], iss_q[1]); end
      vec++; if (cons_a[0] !== 32'h200 || cons_d[0] !== mdata(32'h200)) begin errs++; $display("FAIL jreq_first_word: observed %h/%h, required 00000200/%h", cons_a[0], cons_d[0], mdata(32'h200)); end
   endtask

   task automatic test_jump_flush();
      bit found = 0;
      do_reset();
      tick(5);
      hold = HOLD_PIPE;
      tick(4);
      jump = 1'b1; jaddr = 32'h0000_0302;
      clear_logs();
      tick(1);
      jump = 1'b0; hold = HOLD_NONE;
      vec++; if (inst !== 32'h13 || inst_addr !== 32'h0) begin errs++; $display("FAIL jflush_nop: observed %h/%h, required 00000013/00000000", inst, inst_addr); end
      for (int i = 0; i < 30 && !found; i++) begin
         tick(1);
         if (cons_a.size() > 0) found = 1;
      end
      vec++; if (!found) begin errs++; $display("FAIL jflush_arrive: observed timeout, required data for 00000300"); end
      vec++; if (iss_q[0] !== 32'h300 || cons_a[0] !== 32'h300) begin errs++; $display("FAIL jflush_target: observed issue %h cons %h, required 00000300", iss_q[0], cons_a[0]); end
   endtask

   task automatic test_reset_mid();
      bit found = 0;
      do_reset();
      lat = 1;
      for (int i = 0; i < 40 && !found; i++) begin
         tick(1);
         if (iss_q.size() > 0 && iss_q[iss_q.size() - 1] == 32'h8) found = 1;
      end
      vec++; if (!found) begin errs++; $display("FAIL rstmid_wait: observed timeout, required grant of 00000008"); end
      rst_n = 1'b1;
      #1;
      vec++; if (bus.req !== 1'b0 || bus.addr !== 32'h0 || inst !== 32'h13) begin errs++; $display("FAIL rstmid_async: observed %b/%h/%h, required 0/00000000/00000013", bus.req, bus.addr, inst); end
      tick(1);
      rst_n = 1'b0;
      stray = 1'b1;
      clear_logs();
      tick(2);
      stray = 1'b0;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick(1);
         if (cons_a.size() > 1) found = 1;
      end
      vec++; if (!found) begin errs++; $display("FAIL rstmid_arrive: observed timeout, required two words"); end
      vec++; if (iss_q[0] !== 32'h0) begin errs++; $display("FAIL rstmid_first_req: observed %h, required 00000000", iss_q[0]); end
      vec++; if (cons_a[0] !== 32'h0 || cons_d[0] !== mdata(32'h0)) begin errs++; $display("FAIL rstmid_word0: observed %h/%h, required 00000000/%h", cons_a[0], cons_d[0], mdata(32'h0)); end
      vec++; if (cons_a[1] !== 32'h4 || cons_d[1] !== mdata(32'h4)) begin errs++; $display("FAIL rstmid_word1: observed %h/%h, required 00000004/%h", cons_a[1], cons_d[1], mdata(32'h4)); end
   endtask

   initial begin
      rst_n = 1'b1; jump = 1'b0; jaddr = '0; hold = HOLD_NONE;
      gnt_en = 1'b1; lat = 0; stray = 1'b0;
      test_reset();
      test_stream();
      test_hold_full();
      test_hold_pc();
      test_jump_resp();
      test_jump_req();
      test_jump_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
